// File: rtl/euler_step_engine.sv
// Forward-Euler iterator x += h*(A*x + B*u) over an external 2R/1W RAM.
// Saturating Q-format MAC, ping-pong state buffers, START/DONE handshake.
module euler_step_engine #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int MAX_DIM    = 64,
  parameter int DIM_WIDTH  = 7,
  parameter int STEP_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [DIM_WIDTH-1:0]  N_DIM,
  input  logic [DIM_WIDTH-1:0]  M_DIM,
  input  logic [STEP_WIDTH-1:0] NUM_STEPS,
  input  logic [DATA_WIDTH-1:0] H_VAL,
  input  logic [ADDR_WIDTH-1:0] A_BASE,
  input  logic [ADDR_WIDTH-1:0] B_BASE,
  input  logic [ADDR_WIDTH-1:0] X_BASE,
  input  logic [ADDR_WIDTH-1:0] U_BASE,
  input  logic [ADDR_WIDTH-1:0] XN_BASE,
  output logic [ADDR_WIDTH-1:0] RD_ADDR1,
  output logic [ADDR_WIDTH-1:0] RD_ADDR2,
  input  logic [DATA_WIDTH-1:0] RD_DATA1,
  input  logic [DATA_WIDTH-1:0] RD_DATA2,
  output logic                  WR_EN,
  output logic [ADDR_WIDTH-1:0] WR_ADDR,
  output logic [DATA_WIDTH-1:0] WR_DATA,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR,
  output logic                  OVF,
  output logic                  RESULT_SEL,
  output logic [STEP_WIDTH-1:0] STEP_CNT
);
  localparam int DW = DATA_WIDTH;
  localparam int W2 = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE, CHECK, ROW_A, ROW_B, ROW_X, ROW_WR, FINISH
  } state_t;

  state_t                state_q;
  logic [DIM_WIDTH-1:0]  n_q, m_q, j_q, row_q;
  logic [STEP_WIDTH-1:0] steps_q, step_q;
  logic [DW-1:0]         h_q, acc_q, acc_d;
  logic [ADDR_WIDTH-1:0] a_base_q, b_base_q, u_base_q;
  logic [ADDR_WIDTH-1:0] src_q, dst_q, a_ptr_q, b_ptr_q;
  logic [ADDR_WIDTH-1:0] s_ptr_q, u_ptr_q, xi_q, di_q;
  logic [ADDR_WIDTH-1:0] rd1_q, rd2_q, wr_addr_q;
  logic iss_q, vld_q, wr_en_q, busy_q, done_q;
  logic err_q, ovf_q, ovf_d, rsel_q;

  function automatic logic [DW:0] sat(input logic signed [W2:0] v);
    logic signed [W2:0] mx, mn;
    mx = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
    mn = {{(DW+2){1'b1}}, {(DW-1){1'b0}}};
    if (v > mx)      sat = {2'b10, {(DW-1){1'b1}}};
    else if (v < mn) sat = {2'b11, {(DW-1){1'b0}}};
    else             sat = {1'b0, v[DW-1:0]};
  endfunction

  // Pair product arrives one cycle after its addresses were issued
  logic [W2-1:0]      mul_d, hm_d;
  logic signed [W2:0] pw_d, aw_d, hw_d, xw_d;
  logic [DW:0]        p_sat, a_sat, h_sat, x_sat;

  assign mul_d = {{DW{RD_DATA1[DW-1]}}, RD_DATA1} *
                 {{DW{RD_DATA2[DW-1]}}, RD_DATA2};
  assign pw_d  = {mul_d[W2-1], $signed(mul_d) >>> FRAC_BITS};
  assign p_sat = sat(pw_d);
  assign aw_d  = {{(DW+1){acc_q[DW-1]}}, acc_q} +
                 {{(DW+1){p_sat[DW-1]}}, p_sat[DW-1:0]};
  assign a_sat = sat(aw_d);
  assign hm_d  = {{DW{h_q[DW-1]}}, h_q} *
                 {{DW{acc_q[DW-1]}}, acc_q};
  assign hw_d  = {hm_d[W2-1], $signed(hm_d) >>> FRAC_BITS};
  assign h_sat = sat(hw_d);
  assign xw_d  = {{(DW+1){RD_DATA1[DW-1]}}, RD_DATA1} +
                 {{(DW+1){h_sat[DW-1]}}, h_sat[DW-1:0]};
  assign x_sat = sat(xw_d);

  always_comb begin
    acc_d = acc_q;
    if (state_q == IDLE || state_q == CHECK || state_q == ROW_WR)
      acc_d = '0;
    else if (vld_q)
      acc_d = a_sat[DW-1:0];
  end

  always_comb begin
    ovf_d = ovf_q | (vld_q & (p_sat[DW] | a_sat[DW])) |
            (wr_en_q & (h_sat[DW] | x_sat[DW]));
    if (state_q == IDLE && START)
      ovf_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      n_q <= '0; m_q <= '0; j_q <= '0; row_q <= '0;
      steps_q <= '0; step_q <= '0; h_q <= '0; acc_q <= '0;
      a_base_q <= '0; b_base_q <= '0; u_base_q <= '0;
      src_q <= '0; dst_q <= '0; a_ptr_q <= '0; b_ptr_q <= '0;
      s_ptr_q <= '0; u_ptr_q <= '0; xi_q <= '0; di_q <= '0;
      rd1_q <= '0; rd2_q <= '0; wr_addr_q <= '0;
      iss_q <= 1'b0; vld_q <= 1'b0; wr_en_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
      ovf_q <= 1'b0; rsel_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      vld_q   <= iss_q;
      iss_q   <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (START) begin
          n_q <= N_DIM; m_q <= M_DIM;
          steps_q <= NUM_STEPS; h_q <= H_VAL;
          a_base_q <= A_BASE; b_base_q <= B_BASE;
          u_base_q <= U_BASE;
          src_q <= X_BASE; dst_q <= XN_BASE;
          err_q <= 1'b0; step_q <= '0; rsel_q <= 1'b0;
          busy_q <= 1'b1;
          state_q <= CHECK;
        end
        CHECK: begin
          if (n_q > DIM_WIDTH'(MAX_DIM) ||
              m_q > DIM_WIDTH'(MAX_DIM)) begin
            err_q <= 1'b1;
            done_q <= 1'b1; busy_q <= 1'b0;
            state_q <= FINISH;
          end else if (n_q == '0 || steps_q == '0) begin
            done_q <= 1'b1; busy_q <= 1'b0;
            state_q <= FINISH;
          end else begin
            rd1_q <= a_base_q; a_ptr_q <= a_base_q + 1'b1;
            rd2_q <= src_q; s_ptr_q <= src_q + 1'b1;
            b_ptr_q <= b_base_q;
            xi_q <= src_q; di_q <= dst_q;
            j_q <= '0; row_q <= '0;
            iss_q <= 1'b1;
            state_q <= ROW_A;
          end
        end
        ROW_A: begin
          if (j_q != n_q - 1'b1) begin
            rd1_q <= a_ptr_q; a_ptr_q <= a_ptr_q + 1'b1;
            rd2_q <= s_ptr_q; s_ptr_q <= s_ptr_q + 1'b1;
            j_q <= j_q + 1'b1;
            iss_q <= 1'b1;
          end else if (m_q != '0) begin
            rd1_q <= b_ptr_q; b_ptr_q <= b_ptr_q + 1'b1;
            rd2_q <= u_base_q; u_ptr_q <= u_base_q + 1'b1;
            j_q <= '0;
            iss_q <= 1'b1;
            state_q <= ROW_B;
          end else begin
            rd1_q <= xi_q; rd2_q <= '0;
            state_q <= ROW_X;
          end
        end
        ROW_B: begin
          if (j_q != m_q - 1'b1) begin
            rd1_q <= b_ptr_q; b_ptr_q <= b_ptr_q + 1'b1;
            rd2_q <= u_ptr_q; u_ptr_q <= u_ptr_q + 1'b1;
            j_q <= j_q + 1'b1;
            iss_q <= 1'b1;
          end else begin
            rd1_q <= xi_q; rd2_q <= '0;
            state_q <= ROW_X;
          end
        end
        ROW_X: begin
          rd1_q <= '0;
          wr_en_q <= 1'b1; wr_addr_q <= di_q;
          state_q <= ROW_WR;
        end
        ROW_WR: begin
          wr_addr_q <= '0;
          xi_q <= xi_q + 1'b1; di_q <= di_q + 1'b1;
          row_q <= row_q + 1'b1; j_q <= '0;
          if (row_q != n_q - 1'b1) begin
            rd1_q <= a_ptr_q; a_ptr_q <= a_ptr_q + 1'b1;
            rd2_q <= src_q; s_ptr_q <= src_q + 1'b1;
            iss_q <= 1'b1;
            state_q <= ROW_A;
          end else begin
            step_q <= step_q + 1'b1;
            if (step_q + 1'b1 == steps_q) begin
              done_q <= 1'b1; busy_q <= 1'b0;
              rsel_q <= steps_q[0];
              state_q <= FINISH;
            end else begin
              // Swap buffers: this step's destination feeds the next one
              src_q <= dst_q; dst_q <= src_q;
              xi_q <= dst_q; di_q <= src_q; row_q <= '0;
              b_ptr_q <= b_base_q;
              rd1_q <= a_base_q; a_ptr_q <= a_base_q + 1'b1;
              rd2_q <= dst_q; s_ptr_q <= dst_q + 1'b1;
              iss_q <= 1'b1;
              state_q <= ROW_A;
            end
          end
        end
        FINISH: begin
          rd1_q <= '0; rd2_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign RD_ADDR1   = rd1_q;
  assign RD_ADDR2   = rd2_q;
  assign WR_EN      = wr_en_q;
  assign WR_ADDR    = wr_addr_q;
  assign WR_DATA    = wr_en_q ? x_sat[DW-1:0] : '0;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ERR        = err_q;
  assign OVF        = ovf_q;
  assign RESULT_SEL = rsel_q;
  assign STEP_CNT   = step_q;
endmodule

// File: tb/tb_euler_step_engine.sv
// Directed bench for euler_step_engine with RAM model and write scoreboard.
// Expected writes come from a fixed-point reference model of the solver.
module tb_euler_step_engine;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST_N, START;
  logic [6:0]  N_DIM, M_DIM;
  logic [15:0] NUM_STEPS;
  logic [31:0] H_VAL;
  logic [12:0] A_BASE, B_BASE, X_BASE, U_BASE, XN_BASE;
  logic [12:0] RD_ADDR1, RD_ADDR2, WR_ADDR;
  logic [31:0] RD_DATA1, RD_DATA2, WR_DATA;
  logic        WR_EN, BUSY, DONE, ERR, OVF, RESULT_SEL;
  logic [15:0] STEP_CNT;

  euler_step_engine dut (
    .CLK(CLK), .RST_N(RST_N), .START(START),
    .N_DIM(N_DIM), .M_DIM(M_DIM), .NUM_STEPS(NUM_STEPS),
    .H_VAL(H_VAL), .A_BASE(A_BASE), .B_BASE(B_BASE),
    .X_BASE(X_BASE), .U_BASE(U_BASE), .XN_BASE(XN_BASE),
    .RD_ADDR1(RD_ADDR1), .RD_ADDR2(RD_ADDR2),
    .RD_DATA1(RD_DATA1), .RD_DATA2(RD_DATA2),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .OVF(OVF),
    .RESULT_SEL(RESULT_SEL), .STEP_CNT(STEP_CNT)
  );

  logic [31:0] mem [0:8191];
  logic        hw_en;
  logic [12:0] hw_a;
  logic [31:0] hw_d;

  always @(posedge CLK) begin
    RD_DATA1 <= mem[RD_ADDR1];
    RD_DATA2 <= mem[RD_ADDR2];
    if (WR_EN) mem[WR_ADDR] <= WR_DATA;
    else if (hw_en) mem[hw_a] <= hw_d;
  end

  typedef struct { logic [12:0] a; logic [31:0] d; } wr_t;
  wr_t exq[$];
  int  mm [0:8191];
  int  checks = 0, failures = 0, nwr = 0;
  bit  mov;

  localparam longint MAXV = 64'sh7FFFFFFF;
  localparam longint MINV = -64'sh80000000;
  localparam int AB = 'h100, BB = 'h200, XB = 'h300;
  localparam int UB = 'h400, XNB = 'h500;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (WR_EN === 1'b1) begin
      wr_t e;
      nwr++;
      chk("wr_expected", exq.size() > 0, 1);
      if (exq.size() > 0) begin
        e = exq.pop_front();
        chk("wr_addr", WR_ADDR, e.a);
        chk("wr_data", WR_DATA, e.d);
      end
    end
  end

  function automatic int sat32(longint v);
    if (v > MAXV) begin mov = 1; return 32'h7FFFFFFF; end
    if (v < MINV) begin mov = 1; return 32'h80000000; end
    return int'(v);
  endfunction

  function automatic int fmul(int a, int b);
    longint p = longint'(a) * longint'(b);
    return sat32(p >>> 16);
  endfunction

  function automatic int fadd(int a, int b);
    return sat32(longint'(a) + longint'(b));
  endfunction

  task automatic setmem(int a, int v);
    hw_en = 1'b1; hw_a = 13'(a); hw_d = v;
    mm[a] = v;
    @(negedge CLK);
    hw_en = 1'b0;
  endtask

  task automatic run(int n, int m, int steps, int h, bit glitch);
    bit legal = (n <= 64) && (m <= 64);
    bit deg = !legal || n == 0 || steps == 0;
    int exp_lat, cyc, n0;
    mov = 0;
    if (!deg)
      for (int s = 0; s < steps; s++) begin
        int src = (s % 2 == 0) ? XB : XNB;
        int dst = (s % 2 == 0) ? XNB : XB;
        for (int i = 0; i < n; i++) begin
          int acc = 0, v;
          for (int j = 0; j < n; j++)
            acc = fadd(acc, fmul(mm[AB+i*n+j], mm[src+j]));
          for (int j = 0; j < m; j++)
            acc = fadd(acc, fmul(mm[BB+i*m+j], mm[UB+j]));
          v = fadd(mm[src+i], fmul(h, acc));
          mm[dst+i] = v;
          exq.push_back('{a: 13'(dst+i), d: v});
        end
      end
    exp_lat = deg ? 2 : 2 + steps * n * (n + m + 2);
    @(negedge CLK);
    N_DIM = 7'(n); M_DIM = 7'(m); NUM_STEPS = 16'(steps);
    H_VAL = h; A_BASE = 13'(AB); B_BASE = 13'(BB);
    X_BASE = 13'(XB); U_BASE = 13'(UB); XN_BASE = 13'(XNB);
    START = 1'b1;
    n0 = nwr;
    @(negedge CLK);
    START = 1'b0;
    cyc = 1;
    chk("busy_c1", BUSY, 1);
    chk("ovf_clr", OVF, 0);
    chk("err_clr", ERR, 0);
    while (DONE !== 1'b1 && cyc < exp_lat + 40) begin
      if (glitch && cyc == 4) begin
        START = 1'b1; N_DIM = 7'd1; NUM_STEPS = 16'd7;
      end else START = 1'b0;
      @(negedge CLK);
      cyc++;
    end
    START = 1'b0;
    chk("done_seen", DONE, 1);
    chk("latency", cyc, exp_lat);
    chk("busy_at_done", BUSY, 0);
    chk("err", ERR, !legal);
    chk("ovf", OVF, mov);
    chk("step_cnt", STEP_CNT, deg ? 0 : steps);
    chk("result_sel", RESULT_SEL, deg ? 0 : (steps & 1));
    chk("writes", nwr - n0, deg ? 0 : steps * n);
    chk("queue_drained", exq.size(), 0);
    @(negedge CLK);
    chk("done_pulse", DONE, 0);
  endtask

  task automatic setup1();
    setmem(AB, 'h20000); setmem(BB, 'h10000);
    setmem(XB, 'h10000); setmem(UB, 'h30000);
  endtask

  task automatic setup2();
    setmem(AB, 'h10000); setmem(AB+1, 0);
    setmem(AB+2, 0); setmem(AB+3, 'h10000);
    setmem(XB, 'h20000); setmem(XB+1, 'h40000);
  endtask

  task automatic setup_rand(int n, int m, bit big);
    for (int k = 0; k < n*n; k++)
      setmem(AB+k, big ? int'($urandom()) : int'($urandom_range(0, 'h7FFFF)) - 'h40000);
    for (int k = 0; k < n*m; k++)
      setmem(BB+k, int'($urandom_range(0, 'h7FFFF)) - 'h40000);
    for (int k = 0; k < n; k++)
      setmem(XB+k, big ? int'($urandom()) : int'($urandom_range(0, 'h7FFFF)) - 'h40000);
    for (int k = 0; k < m; k++)
      setmem(UB+k, int'($urandom_range(0, 'h7FFFF)) - 'h40000);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_addr"}, {RD_ADDR1, RD_ADDR2, WR_ADDR, WR_EN}, 0);
    chk({tag, "_ctl"},
        {WR_DATA, STEP_CNT, BUSY, DONE, ERR, OVF, RESULT_SEL}, 0);
  endtask

  initial begin
    int n0;
    RST_N = 1'b0; START = 1'b0; hw_en = 1'b0; hw_a = '0; hw_d = '0;
    N_DIM = '0; M_DIM = '0; NUM_STEPS = '0; H_VAL = '0;
    A_BASE = '0; B_BASE = '0; X_BASE = '0; U_BASE = '0; XN_BASE = '0;
    repeat (3) @(negedge CLK);
    chk_zero("reset");
    RST_N = 1'b1;

    setup1(); run(1, 1, 1, 'h10000, 0);
    setup2(); run(2, 0, 2, 'h8000, 0);
    setmem(AB, 'h7FFF0000); setmem(XB, 'h7FFF0000);
    run(1, 0, 1, 'h10000, 0);
    setup1(); run(1, 1, 1, 'h10000, 0);
    run(0, 1, 3, 'h10000, 0);
    run(65, 1, 1, 'h10000, 0);
    run(2, 65, 1, 'h10000, 0);
    run(2, 1, 0, 'h10000, 0);

    setup2();
    @(negedge CLK);
    N_DIM = 7'd2; M_DIM = 7'd0; NUM_STEPS = 16'd2; H_VAL = 'h8000;
    A_BASE = 13'(AB); X_BASE = 13'(XB); XN_BASE = 13'(XNB);
    exq.push_back('{a: 13'(XNB), d: 32'h30000});
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (6) @(negedge CLK);
    chk("busy_mid", BUSY, 1);
    RST_N = 1'b0;
    @(negedge CLK);
    chk_zero("mid_reset");
    chk("rst_q_drained", exq.size(), 0);
    RST_N = 1'b1;
    n0 = nwr;
    repeat (30) @(negedge CLK);
    chk("no_wr_after_rst", nwr - n0, 0);
    setup1(); run(1, 1, 1, 'h10000, 0);

    setup2(); run(2, 0, 2, 'h8000, 1);
    setup_rand(3, 2, 0); run(3, 2, 3, 'h4000, 0);
    setup_rand(4, 3, 1); run(4, 3, 2, 'h18000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/euler_step_engine.md
Name: euler_step_engine

Overview:
- Parametrised successor to the fixed-size Euler solver.
- Runs NUM_STEPS forward-Euler iterations of x[k+1] = x[k] + h*(A*x[k] + B*u) on signed fixed-point data held in an external 2-read/1-write RAM.
- Runtime N/M dimensions and base addresses; saturating arithmetic with a sticky overflow flag; ping-pong state buffers; START/DONE handshake.
- Sits between the host/interpolation controller and the shared data RAM.

Parameters:
ADDR_WIDTH, 13, RAM address width
DATA_WIDTH, 32, signed two's-complement word width
FRAC_BITS, 16, fractional bits of every word, h included
MAX_DIM, 64, largest legal N_DIM or M_DIM
DIM_WIDTH, 7, width of N_DIM and M_DIM
STEP_WIDTH, 16, width of NUM_STEPS and STEP_CNT

Ports:
CLK  in  1  clock; all logic on posedge
RST_N  in  1  synchronous active-low reset
START  in  1  one-cycle start request, sampled in IDLE only
N_DIM  in  DIM_WIDTH  state dimension N
M_DIM  in  DIM_WIDTH  input dimension M
NUM_STEPS  in  STEP_WIDTH  number of Euler iterations
H_VAL  in  DATA_WIDTH  step size h
A_BASE, B_BASE, X_BASE, U_BASE, XN_BASE  in  ADDR_WIDTH each  base addresses; A and B row-major (A[i][j] at A_BASE+i*N+j)
RD_ADDR1, RD_ADDR2  out  ADDR_WIDTH  RAM read addresses; data is returned one cycle later
RD_DATA1, RD_DATA2  in  DATA_WIDTH  RAM read data
WR_EN  out  1  RAM write strobe
WR_ADDR  out  ADDR_WIDTH  RAM write address
WR_DATA  out  DATA_WIDTH  RAM write data
BUSY  out  1  high from the cycle after START until DONE
DONE  out  1  one-cycle completion pulse
ERR  out  1  set when a dimension is illegal; cleared on START
OVF  out  1  sticky saturation flag; cleared on START
RESULT_SEL  out  1  0: final x is at X_BASE, 1: final x is at XN_BASE
STEP_CNT  out  STEP_WIDTH  completed iterations

Behaviour:
- Reset (RST_N=0 at a posedge) forces state IDLE. All outputs go to 0: RD_ADDR*, WR_*, BUSY, DONE, ERR, OVF, RESULT_SEL, STEP_CNT. The accumulator clears. Reset mid-run aborts immediately, and no further writes occur.
- START in IDLE:
  - Latches all dimension, step, h and base inputs, and clears ERR, OVF and STEP_CNT.
  - START in any other state is ignored.
- Degenerate and illegal starts:
  - N_DIM==0 or NUM_STEPS==0: enter FINISH with no RAM writes.
  - N_DIM>MAX_DIM or M_DIM>MAX_DIM: set ERR, then FINISH with no writes.
- States: IDLE -> ROW_A -> ROW_B -> ROW_X -> ROW_WR -> (next row: ROW_A | next step: ROW_A | last: FINISH) -> IDLE.
  - ROW_A, N cycles: RD_ADDR1 = A[i][j], RD_ADDR2 = src[j].
  - ROW_B, M cycles, skipped if M=0: RD_ADDR1 = B[i][j], RD_ADDR2 = U[j].
  - ROW_X, 1 cycle: RD_ADDR1 = src[i].
  - ROW_WR, 1 cycle: WR_EN=1, WR_ADDR = dst[i], WR_DATA = sat(x_i + sat((h*acc) >>> FRAC_BITS)).
  - FINISH, 1 cycle: DONE=1, BUSY=0.
- Addresses are produced by incrementing pointers; no multipliers in address paths.
- MAC pipeline:
  - Each issued pair is multiplied one cycle later when its data arrives: product = (d1*d2) >>> FRAC_BITS, saturated to DATA_WIDTH, then accumulated with saturation.
  - The accumulator clears at the start of each row.
  - The last B product lands in ROW_X; x_i arrives in ROW_WR.
- Row and step timing:
  - Each row takes N+M+2 cycles.
  - Each step takes N*(N+M+2) cycles.
  - DONE pulses in the cycle after the final ROW_WR.
  - The total START-to-DONE is 1 + NUM_STEPS*N*(N+M+2) + 1 cycles.
- Ping-pong buffers:
  - Even step k: src=X_BASE, dst=XN_BASE. Odd step: src=XN_BASE, dst=X_BASE.
  - STEP_CNT increments after each step's last write.
  - RESULT_SEL = NUM_STEPS[0], valid when DONE pulses.
- Saturation: any clamp to +max 0x7FFF_FFFF or -min 0x8000_0000 (DATA_WIDTH=32) sets OVF; OVF holds until the next START.
- Rounding: arithmetic right shift truncates toward minus infinity.
- WR_EN is low in every state except ROW_WR.

Test Plan:
- N=1, M=1, h=0x10000, A=0x20000, B=0x10000, X=0x10000, U=0x30000, 1 step -> one write of 0x60000 to XN_BASE; DONE 6 cycles after START; RESULT_SEL=1, STEP_CNT=1, OVF=0.
- N=2, M=0, A=identity, h=0x8000, X=[0x20000,0x40000], 2 steps -> XN=[0x30000,0x60000], then X=[0x48000,0x90000]; RESULT_SEL=0; 4 writes total.
- N=1, M=0, A=0x7FFF0000, X=0x7FFF0000, h=0x10000 -> WR_DATA=0x7FFFFFFF, OVF=1; next START clears OVF.
- N_DIM=0 -> DONE 2 cycles after START, no WR_EN; N_DIM=65 -> ERR=1 with DONE, no writes.
- Pulse RST_N low mid-step -> all outputs 0 next cycle, no further WR_EN; a new START runs case 1 correctly.
- START re-asserted while BUSY -> ignored; results and cycle count identical to case 2.
